// File: rtl/rv32i_pipelined_core.sv
// rv32i_pipelined_core
//   Five-stage (F/D/E/M/W) in-order RV32I-subset core with a Harvard interface.
//   Supported: lw sw add sub and or slt addi andi ori slti beq jal; anything
//   else decodes as a NOP. Hazards: M->E / W->E forwarding, one-cycle load-use
//   stall, and a two-cycle flush on a taken beq or jal, resolved in E.
// Ports
//   clk        rising-edge clock (register file writes on the falling edge)
//   reset      asynchronous, active-low
//   pc         F-stage fetch address
//   instr      instruction at pc (combinational ROM)
//   mem_write  M-stage store enable (word)
//   mem_addr   M-stage byte address
//   mem_wdata  M-stage store data
//   mem_rdata  load data, returned one cycle after mem_addr (during W)
module rv32i_pipelined_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] pc,
  input  logic [31:0] instr,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {RES_ALU, RES_MEM, RES_PC4} res_e;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_e;

  typedef struct packed {
    logic    regwrite;
    logic    memwrite;
    logic    branch;
    logic    jump;
    logic    alusrc;
    res_e    res_src;
    alu_op_e alu_op;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } fd_t;

  typedef struct packed {
    ctrl_t       ctrl;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } de_t;

  typedef struct packed {
    logic        regwrite;
    logic        memwrite;
    res_e        res_src;
    logic [31:0] alu;
    logic [31:0] wdata;
    logic [31:0] pc4;
    logic [4:0]  rd;
  } em_t;

  typedef struct packed {
    logic        regwrite;
    res_e        res_src;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [4:0]  rd;
  } mw_t;

  fd_t fd, fd_next;
  de_t de, de_next;
  em_t em, em_next;
  mw_t mw, mw_next;

  logic [31:0] pc4_f;

  // ---------------------------------------------------------------- decode
  logic [6:0]  opcode, f7;
  logic [2:0]  f3;
  logic [4:0]  rs1_d, rs2_d, rd_d;
  ctrl_t       ctrl_d;
  logic [31:0] imm_d, rd1_d, rd2_d;

  assign opcode = fd.instr[6:0];
  assign rd_d   = fd.instr[11:7];
  assign f3     = fd.instr[14:12];
  assign rs1_d  = fd.instr[19:15];
  assign rs2_d  = fd.instr[24:20];
  assign f7     = fd.instr[31:25];

  always_comb begin
    ctrl_d = '0;
    imm_d  = '0;
    case (opcode)
      OP_LOAD: begin
        imm_d = {{20{fd.instr[31]}}, fd.instr[31:20]};
        if (f3 == 3'b010) begin
          ctrl_d.regwrite = 1'b1;
          ctrl_d.alusrc   = 1'b1;
          ctrl_d.res_src  = RES_MEM;
        end
      end
      OP_STORE: begin
        imm_d = {{20{fd.instr[31]}}, fd.instr[31:25], fd.instr[11:7]};
        if (f3 == 3'b010) begin
          ctrl_d.memwrite = 1'b1;
          ctrl_d.alusrc   = 1'b1;
        end
      end
      OP_REG: begin
        ctrl_d.regwrite = 1'b1;
        case ({f7, f3})
          10'b0000000_000: ctrl_d.alu_op = ALU_ADD;
          10'b0100000_000: ctrl_d.alu_op = ALU_SUB;
          10'b0000000_111: ctrl_d.alu_op = ALU_AND;
          10'b0000000_110: ctrl_d.alu_op = ALU_OR;
          10'b0000000_010: ctrl_d.alu_op = ALU_SLT;
          default:         ctrl_d.regwrite = 1'b0;
        endcase
      end
      OP_IMM: begin
        imm_d           = {{20{fd.instr[31]}}, fd.instr[31:20]};
        ctrl_d.regwrite = 1'b1;
        ctrl_d.alusrc   = 1'b1;
        case (f3)
          3'b000:  ctrl_d.alu_op = ALU_ADD;
          3'b111:  ctrl_d.alu_op = ALU_AND;
          3'b110:  ctrl_d.alu_op = ALU_OR;
          3'b010:  ctrl_d.alu_op = ALU_SLT;
          default: begin
            ctrl_d.regwrite = 1'b0;
            ctrl_d.alusrc   = 1'b0;
          end
        endcase
      end
      OP_BRANCH: begin
        imm_d = {{19{fd.instr[31]}}, fd.instr[31], fd.instr[7],
                 fd.instr[30:25], fd.instr[11:8], 1'b0};
        if (f3 == 3'b000) begin
          ctrl_d.branch = 1'b1;
          ctrl_d.alu_op = ALU_SUB;
        end
      end
      OP_JAL: begin
        imm_d = {{11{fd.instr[31]}}, fd.instr[31], fd.instr[19:12],
                 fd.instr[20], fd.instr[30:21], 1'b0};
        ctrl_d.jump     = 1'b1;
        ctrl_d.regwrite = 1'b1;
        ctrl_d.res_src  = RES_PC4;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------- register file
  // Written on the falling edge so an instruction in D picks up the value
  // being retired in W during the same cycle.
  logic [31:0] rf [32];
  logic [31:0] result_w;

  always_ff @(negedge clk)
    if (mw.regwrite && mw.rd != 5'd0) rf[mw.rd] <= result_w;

  assign rd1_d = (rs1_d == 5'd0) ? 32'd0 : rf[rs1_d];
  assign rd2_d = (rs2_d == 5'd0) ? 32'd0 : rf[rs2_d];

  // --------------------------------------------------------------- execute
  logic [31:0] fwd_a, fwd_b, srcb, alu_y, m_fwd, target;
  logic        redirect, lwstall;

  // M-stage forward value; a jal in M forwards its link address.
  assign m_fwd = (em.res_src == RES_PC4) ? em.pc4 : em.alu;

  always_comb begin
    fwd_a = de.rd1;
    if (em.regwrite && em.rd != 5'd0 && em.rd == de.rs1)      fwd_a = m_fwd;
    else if (mw.regwrite && mw.rd != 5'd0 && mw.rd == de.rs1) fwd_a = result_w;
    fwd_b = de.rd2;
    if (em.regwrite && em.rd != 5'd0 && em.rd == de.rs2)      fwd_b = m_fwd;
    else if (mw.regwrite && mw.rd != 5'd0 && mw.rd == de.rs2) fwd_b = result_w;
  end

  assign srcb = de.ctrl.alusrc ? de.imm : fwd_b;

  always_comb begin
    case (de.ctrl.alu_op)
      ALU_ADD: alu_y = fwd_a + srcb;
      ALU_SUB: alu_y = fwd_a - srcb;
      ALU_AND: alu_y = fwd_a & srcb;
      ALU_OR:  alu_y = fwd_a | srcb;
      ALU_SLT: alu_y = {31'd0, $signed(fwd_a) < $signed(srcb)};
      default: alu_y = 32'd0;
    endcase
  end

  assign redirect = (de.ctrl.branch && alu_y == 32'd0) || de.ctrl.jump;
  assign target   = de.pc + de.imm;

  // A load in E whose destination is read by D must wait one cycle so its
  // data can be forwarded from W; bubbles have regwrite clear.
  assign lwstall = de.ctrl.regwrite && de.ctrl.res_src == RES_MEM &&
                   (de.rd == rs1_d || de.rd == rs2_d);

  // ------------------------------------------------------------- writeback
  always_comb begin
    case (mw.res_src)
      RES_MEM: result_w = mem_rdata;
      RES_PC4: result_w = mw.pc4;
      default: result_w = mw.alu;
    endcase
  end

  // ------------------------------------------------------- pipeline regs
  assign pc4_f = pc + 32'd4;

  always_comb begin
    fd_next.instr = instr;
    fd_next.pc    = pc;
    fd_next.pc4   = pc4_f;

    de_next.ctrl  = ctrl_d;
    de_next.rd1   = rd1_d;
    de_next.rd2   = rd2_d;
    de_next.imm   = imm_d;
    de_next.pc    = fd.pc;
    de_next.pc4   = fd.pc4;
    de_next.rs1   = rs1_d;
    de_next.rs2   = rs2_d;
    de_next.rd    = rd_d;

    em_next.regwrite = de.ctrl.regwrite;
    em_next.memwrite = de.ctrl.memwrite;
    em_next.res_src  = de.ctrl.res_src;
    em_next.alu      = alu_y;
    em_next.wdata    = fwd_b;
    em_next.pc4      = de.pc4;
    em_next.rd       = de.rd;

    mw_next.regwrite = em.regwrite;
    mw_next.res_src  = em.res_src;
    mw_next.alu      = em.alu;
    mw_next.pc4      = em.pc4;
    mw_next.rd       = em.rd;
  end

  // Redirect beats stall on pc and F/D; E takes a bubble on either.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= RESET_PC;
      fd <= '0;
      de <= '0;
      em <= '0;
      mw <= '0;
    end else begin
      if (redirect)     pc <= target;
      else if (!lwstall) pc <= pc4_f;

      if (redirect)      fd <= '0;
      else if (!lwstall) fd <= fd_next;

      if (redirect || lwstall) de <= '0;
      else                     de <= de_next;

      em <= em_next;
      mw <= mw_next;
    end
  end

  assign mem_write = em.memwrite;
  assign mem_addr  = em.alu;
  assign mem_wdata = em.wdata;

endmodule

// File: tb/tb_rv32i_pipelined_core.sv
// tb_rv32i_pipelined_core
//   Directed and randomized programs. Expected store streams come from an
//   instruction-level model that executes the generated program list
//   directly (no bit-level decoding, no pipeline timing); directed steps use
//   hand-derived constants, including store cycle numbers.
module tb_rv32i_pipelined_core;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc, instr, mem_addr, mem_wdata, mem_rdata;
  logic        mem_write;

  rv32i_pipelined_core #(.RESET_PC(32'h0000_0000)) dut (
    .clk       (clk),
    .reset     (reset),
    .pc        (pc),
    .instr     (instr),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  localparam int O_ADDI = 0, O_ANDI = 1, O_ORI = 2, O_SLTI = 3, O_ADD = 4,
                 O_SUB = 5, O_AND = 6, O_OR = 7, O_SLT = 8, O_LW = 9,
                 O_SW = 10, O_BEQ = 11, O_JAL = 12, O_HALT = 13;

  typedef struct {
    int op;
    int rd;
    int rs1;
    int rs2;
    int imm;
  } ins_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } st_t;

  ins_t        prog [64];
  logic [31:0] rom [1024];
  logic [31:0] ram [32768];
  logic [31:0] ram_init [64];
  st_t         st_q [$];
  st_t         exp_q [$];
  int          cyc;
  int          checks = 0;
  int          errors = 0;

  assign instr = rom[pc[11:2]];

  // Synchronous data RAM; reloads its low words from ram_init while in reset.
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 64; i++) ram[i] <= ram_init[i];
    end else if (mem_write) begin
      ram[mem_addr[16:2]] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr[16:2]];
  end

  always @(posedge clk or negedge reset)
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset)         st_q.delete();
    else if (mem_write) st_q.push_back('{addr: mem_addr, data: mem_wdata, cyc: cyc});
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [31:0] enc(input ins_t x);
    logic [31:0] im;
    logic [4:0]  d, s1, s2;
    im = x.imm;
    d  = 5'(x.rd);
    s1 = 5'(x.rs1);
    s2 = 5'(x.rs2);
    case (x.op)
      O_ADDI: enc = {im[11:0], s1, 3'b000, d, 7'b0010011};
      O_ANDI: enc = {im[11:0], s1, 3'b111, d, 7'b0010011};
      O_ORI:  enc = {im[11:0], s1, 3'b110, d, 7'b0010011};
      O_SLTI: enc = {im[11:0], s1, 3'b010, d, 7'b0010011};
      O_ADD:  enc = {7'b0000000, s2, s1, 3'b000, d, 7'b0110011};
      O_SUB:  enc = {7'b0100000, s2, s1, 3'b000, d, 7'b0110011};
      O_AND:  enc = {7'b0000000, s2, s1, 3'b111, d, 7'b0110011};
      O_OR:   enc = {7'b0000000, s2, s1, 3'b110, d, 7'b0110011};
      O_SLT:  enc = {7'b0000000, s2, s1, 3'b010, d, 7'b0110011};
      O_LW:   enc = {im[11:0], s1, 3'b010, d, 7'b0000011};
      O_SW:   enc = {im[11:5], s2, s1, 3'b010, im[4:0], 7'b0100011};
      O_BEQ:  enc = {im[12], im[10:5], s2, s1, 3'b000, im[4:1], im[11], 7'b1100011};
      O_JAL:  enc = {im[20], im[10:1], im[11], im[19:12], d, 7'b1101111};
      default: enc = 32'h0000_006F;  // jal x0,0: spin in place
    endcase
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 64; i++) prog[i] = '{O_HALT, 0, 0, 0, 0};
  endtask

  task automatic load_rom();
    for (int i = 0; i < 1024; i++) rom[i] = (i < 64) ? enc(prog[i]) : 32'h0;
  endtask

  // Instruction-level reference: executes prog[] one instruction at a time.
  task automatic run_model();
    logic [31:0] r [32];
    logic [31:0] m [64];
    logic [31:0] a, b, im;
    int p, steps;
    ins_t x;
    exp_q.delete();
    for (int i = 0; i < 32; i++) r[i] = 32'd0;
    for (int i = 0; i < 64; i++) m[i] = ram_init[i];
    p = 0;
    steps = 0;
    while (prog[p].op != O_HALT && steps < 1000) begin
      x  = prog[p];
      a  = r[x.rs1];
      b  = r[x.rs2];
      im = x.imm;
      p++;
      steps++;
      case (x.op)
        O_ADDI: r[x.rd] = a + im;
        O_ANDI: r[x.rd] = a & im;
        O_ORI:  r[x.rd] = a | im;
        O_SLTI: r[x.rd] = ($signed(a) < $signed(im)) ? 32'd1 : 32'd0;
        O_ADD:  r[x.rd] = a + b;
        O_SUB:  r[x.rd] = a - b;
        O_AND:  r[x.rd] = a & b;
        O_OR:   r[x.rd] = a | b;
        O_SLT:  r[x.rd] = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        O_LW:   r[x.rd] = m[x.imm / 4];
        O_SW: begin
          m[x.imm / 4] = b;
          exp_q.push_back('{addr: im, data: b, cyc: 0});
        end
        O_BEQ: if (a == b) p = p - 1 + x.imm / 4;
        O_JAL: begin
          r[x.rd] = 32'(4 * p);
          p = p - 1 + x.imm / 4;
        end
        default: ;
      endcase
      r[0] = 32'd0;
    end
  endtask

  // Prologue seeds x1..x7, random body uses x0..x7, tail stores x1..x7.
  task automatic gen_prog();
    int n, body, tail, op, off;
    clear_prog();
    n = 0;
    for (int i = 1; i < 8; i++) prog[n++] = '{O_ADDI, i, 0, 0, int'($urandom_range(0, 4095)) - 2048};
    body = 24;
    tail = 7 + body;
    for (int k = 0; k < body; k++) begin
      op = int'($urandom_range(O_ADDI, O_JAL));
      prog[n] = '{op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 4095)) - 2048};
      if (op == O_LW || op == O_SW) begin
        prog[n].rs1 = 0;
        prog[n].imm = 4 * int'($urandom_range(0, 15));
      end else if (op == O_BEQ || op == O_JAL) begin
        off = int'($urandom_range(1, 3));
        if (n + off > tail) off = tail - n;
        prog[n].imm = 4 * off;
        if (op == O_BEQ && $urandom_range(0, 1) == 1) prog[n].rs2 = prog[n].rs1;
      end
      n++;
    end
    for (int i = 1; i < 8; i++) prog[n++] = '{O_SW, 0, 0, i, 200 + 4 * i};
    prog[n] = '{O_HALT, 0, 0, 0, 0};
    for (int i = 0; i < 64; i++) ram_init[i] = $urandom;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic check_stores(input string tag);
    check({tag, " count"}, 64'(st_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < st_q.size(); i++)
      check($sformatf("%s store%0d", tag, i), {st_q[i].addr, st_q[i].data},
            {exp_q[i].addr, exp_q[i].data});
  endtask

  task automatic set_ins(input int i, input int op, input int rd, input int rs1,
                         input int rs2, input int imm);
    prog[i] = '{op, rd, rs1, rs2, imm};
  endtask

  logic [31:0] d_addr [5];
  logic [31:0] d_data [5];
  int          d_cyc  [5];

  initial begin
    reset = 1'b1;
    #2 reset = 1'b0;

    // Directed program: forwarding, load-use, branches, jal.
    clear_prog();
    set_ins(0,  O_ADDI, 2, 0, 0, 5);
    set_ins(1,  O_ADDI, 3, 2, 0, 7);
    set_ins(2,  O_ADD,  4, 3, 2, 0);
    set_ins(3,  O_SW,   0, 0, 4, 96);
    set_ins(4,  O_ADDI, 4, 4, 0, 8);
    set_ins(5,  O_SW,   0, 0, 4, 100);
    set_ins(6,  O_LW,   5, 0, 0, 100);
    set_ins(7,  O_ADD,  6, 5, 0, 0);
    set_ins(8,  O_SW,   0, 0, 6, 96);
    set_ins(9,  O_BEQ,  0, 0, 2, 12);   // not taken
    set_ins(10, O_SW,   0, 0, 2, 104);
    set_ins(11, O_BEQ,  0, 2, 2, 12);   // taken, skips the store of 7
    set_ins(12, O_ADDI, 7, 0, 0, 7);
    set_ins(13, O_SW,   0, 0, 7, 100);
    set_ins(14, O_JAL,  1, 0, 0, 8);    // x1 = 60
    set_ins(15, O_ADDI, 1, 0, 0, 99);
    set_ins(16, O_SW,   0, 0, 1, 108);
    load_rom();
    for (int i = 0; i < 64; i++) ram_init[i] = 32'd0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst pc", 64'(pc), 64'h0);
    check("rst mem_write", 64'(mem_write), 64'h0);
    check("rst mem_addr", 64'(mem_addr), 64'h0);
    check("rst mem_wdata", 64'(mem_wdata), 64'h0);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("pc seq %0d", k), 64'(pc), 64'(4 * k));
      @(negedge clk);
    end
    repeat (60) @(negedge clk);

    d_addr = '{32'd96, 32'd100, 32'd96, 32'd104, 32'd108};
    d_data = '{32'd17, 32'd25,  32'd25, 32'd5,   32'd60};
    d_cyc  = '{6, 8, 12, 14, 21};
    check("dir count", 64'(st_q.size()), 64'd5);
    for (int i = 0; i < 5 && i < st_q.size(); i++) begin
      check($sformatf("dir store%0d", i), {st_q[i].addr, st_q[i].data}, {d_addr[i], d_data[i]});
      check($sformatf("dir cycle%0d", i), 64'(st_q[i].cyc), 64'(d_cyc[i]));
    end

    // Randomized programs against the instruction-level model.
    for (int t = 0; t < 8; t++) begin
      gen_prog();
      load_rom();
      run_model();
      do_reset();
      repeat (250) @(negedge clk);
      check_stores($sformatf("rand%0d", t));
    end

    // Reset mid-program: outputs drop immediately, then a clean rerun.
    gen_prog();
    load_rom();
    run_model();
    do_reset();
    repeat (40) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("midrst mem_write", 64'(mem_write), 64'h0);
    check("midrst mem_addr", 64'(mem_addr), 64'h0);
    check("midrst pc", 64'(pc), 64'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("midrst hold%0d", k), {31'd0, mem_write, pc}, 64'h0);
    end
    reset = 1'b1;
    repeat (250) @(negedge clk);
    check_stores("restart");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
